fsm_stim_fifo: RTL and testbench
================================

Name: fsm_stim_fifo

Overview:
- Upstream feeder for the 4-bit state machine stage, which consumes one 2-bit input symbol `y` per step.
- Buffers a stream of 2-bit symbols from a producer (bench, host or sequencer) in a small FIFO.
- Presents the head symbol to the FSM as `y` and pops it each time the FSM steps.
- Tracks consumed symbols and flags underrun, so a stalled producer cannot silently feed a stale `y`.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, ≥ 2.
- COUNT_W, 8: width of the consumed-symbol counter.
- IDLE_SYM, 2'd0: value driven on `y` while the FIFO is empty.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers `in_sym` this cycle.
- in_sym  input  2  symbol offered by the producer.
- in_ready  output  1  FIFO can accept a symbol; equals !full.
- adv  input  1  FSM step strobe; requests a pop of the head symbol.
- y  output  2  head symbol to the FSM input; IDLE_SYM when empty.
- y_valid  output  1  head symbol is real data; equals !empty.
- underrun  output  1  sticky flag: `adv` seen while empty.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- count  output  COUNT_W  number of successful pops, mod 2^COUNT_W.

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-high (`reset`).
- Reset, asserted at any time including mid-stream:
  - Read/write pointers and `level` cleared to 0; `count` = 0; `underrun` = 0.
  - Outputs: `y` = IDLE_SYM, `y_valid` = 0, `in_ready` = 1.
  - Storage contents are don't-care; all buffered data is discarded.
- Push: accepted when in_valid & in_ready at a posedge.
  - Written at wr_ptr; wr_ptr increments mod DEPTH.
  - `in_ready` is evaluated on pre-edge state. When full, a push is refused even if `adv` pops in the same cycle.
- Pop: occurs when adv & y_valid at a posedge.
  - rd_ptr increments mod DEPTH; `count` increments and wraps silently at 2^COUNT_W.
- `y` and `y_valid` are decoded from the storage array and pointers only, never from `in_sym`.
  - A symbol pushed into an empty FIFO is visible on `y` one cycle later.
  - Minimum write-to-`y` latency is 1 cycle.
- `y` is stable for the whole cycle and changes only after a posedge.
  - The FSM samples `y` with the same `adv` cycle.
- Underrun: adv & !y_valid at a posedge sets `underrun`.
  - No pointer or `count` change.
  - `underrun` clears only on reset.
- Simultaneous push + pop, not full, not empty: both occur, `level` unchanged.
- Simultaneous push + adv while empty: push occurs, `underrun` is set, and the new symbol appears next cycle.
- `level` update per edge:
  - +1 for push only.
  - −1 for pop only.
  - Unchanged otherwise.
- Pointers are log2(DEPTH) bits. Full/empty are derived from `level` (level == DEPTH / level == 0), not pointer equality.
- There is no state machine beyond the pointers and counters. Sequential state: mem, rd_ptr, wr_ptr, level, count, underrun.

Optional Feature:
- FSM_STIM_LOOP_EN defined:
  - Adds input port `loop` (1 bit).
  - While loop=1, each successful pop also rewrites the popped symbol at wr_ptr and advances wr_ptr. `level` stays constant, so the buffered sequence replays cyclically to the FSM.
  - `in_ready` is forced to 0 while loop=1.
  - `count` still increments on each pop; underrun rules are unchanged.
- Undefined:
  - No `loop` port; pops are always destructive.

Test Plan:
- Reset check: assert `reset` mid-cycle, asynchronously, with no clk edge → `y`=0, `y_valid`=0, `level`=0, `count`=0, `underrun`=0, `in_ready`=1 immediately.
- Ordered stream:
  - Stimulus: push 1,2,3,2,3,2,1,0 (level reaches 8), then `adv` for 8 cycles.
  - Response: `y` sequence 1,2,3,2,3,2,1,0; `count`=8; `level`=0; `y_valid`=0 afterwards.
- Full boundary: with 8 entries held, push 3 with adv=1 → `in_ready` was 0, symbol dropped, `level`=7, `count`+1.
- Underrun:
  - Stimulus: while empty, in_valid=1 with in_sym=2 and adv=1 in the same cycle.
  - Response: `underrun`=1 and sticky; `count` unchanged; next cycle `y`=2, `y_valid`=1, `level`=1.
- Concurrent push/pop and reset mid-stream:
  - At level 3, push 1 and pop together → `level`=3 and FIFO order preserved.
  - Then assert `reset` → everything is cleared, and a push after reset is seen on `y` one cycle later.
- Loop mode (FSM_STIM_LOOP_EN): load 1,3,2, set loop=1, adv for 7 cycles → `y` = 1,3,2,1,3,2,1; `level`=3; `in_ready`=0; `count`=7.

Source files
------------

// File: rtl/fsm_stim_fifo.sv
// Symbol FIFO feeding the 2-bit `y` input of the 4-bit FSM stage; pops on each `adv` step.
// Define FSM_STIM_LOOP_EN to add the `loop` port that replays the buffered sequence cyclically.
module fsm_stim_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned COUNT_W  = 8,
  parameter logic [1:0]  IDLE_SYM = 2'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               in_sym,
  output logic                     in_ready,
  input  logic                     adv,
`ifdef FSM_STIM_LOOP_EN
  input  logic                     loop,
`endif
  output logic [1:0]               y,
  output logic                     y_valid,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic [COUNT_W-1:0]       count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [1:0]         mem [DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LvlW-1:0]    level_q;
  logic [COUNT_W-1:0] count_q;
  logic               underrun_q;

  logic full, empty, loop_on;
  logic do_push, do_pop, do_wr;
  logic [1:0] wr_data;

`ifdef FSM_STIM_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);

  assign in_ready = !full && !loop_on;
  assign y_valid  = !empty;
  assign y        = empty ? IDLE_SYM : mem[rd_ptr_q];
  assign underrun = underrun_q;
  assign level    = level_q;
  assign count    = count_q;

  assign do_push = in_valid && in_ready;
  assign do_pop  = adv && !empty;
  // In loop mode the popped head is recirculated to the tail; in_ready is 0 so no push collides.
  assign do_wr   = do_push || (do_pop && loop_on);
  assign wr_data = loop_on ? mem[rd_ptr_q] : in_sym;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q  <= count_q + COUNT_W'(1);
      end
      if (adv && empty) begin
        underrun_q <= 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (do_pop && !do_push && !loop_on) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_stim_fifo.sv
// Directed self-checking bench for fsm_stim_fifo; covers loop mode when FSM_STIM_LOOP_EN is defined.
module tb_fsm_stim_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       in_ready;
  logic       adv;
  logic       loop;
  logic [1:0] y;
  logic       y_valid;
  logic       underrun;
  logic [3:0] level;
  logic [7:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_stim_fifo #(.DEPTH(8), .COUNT_W(8), .IDLE_SYM(2'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sym   (in_sym),
    .in_ready (in_ready),
    .adv      (adv),
`ifdef FSM_STIM_LOOP_EN
    .loop     (loop),
`endif
    .y        (y),
    .y_valid  (y_valid),
    .underrun (underrun),
    .level    (level),
    .count    (count)
  );

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s);
    in_valid = 1'b1;
    in_sym   = s;
    step();
    in_valid = 1'b0;
  endtask

  // Raise reset between clock edges and check that everything clears with no edge.
  task automatic async_reset(input string tag);
    in_valid = 1'b0;
    adv      = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (y !== 2'd0 || y_valid !== 1'b0 || level !== 4'd0 || count !== 8'd0 ||
        underrun !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got y=%0d y_valid=%0b level=%0d count=%0d underrun=%0b in_ready=%0b, want 0 0 0 0 0 1",
               tag, y, y_valid, level, count, underrun, in_ready);
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    push(2'd3);
    push(2'd1);
    adv = 1'b1;
    step();
    step();
    step();
    adv = 1'b0;
    n_tests++;
    if (underrun !== 1'b1 || count !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_setup: got underrun=%0b count=%0d, want 1 2", underrun, count);
    end
    async_reset("reset_async");
  endtask

  task automatic test_ordered();
    logic [1:0] seq [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 8; i++) push(seq[i]);
    n_tests++;
    if (level !== 4'd8 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ordered_full: got level=%0d in_ready=%0b, want 8 0", level, in_ready);
    end
    adv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (y !== seq[i] || y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ordered_y[%0d]: got y=%0d y_valid=%0b, want %0d 1", i, y, y_valid, seq[i]);
      end
      step();
    end
    adv = 1'b0;
    n_tests++;
    if (count !== 8'd8 || level !== 4'd0 || y_valid !== 1'b0 || y !== 2'd0) begin
      n_fail++;
      $display("FAIL ordered_end: got count=%0d level=%0d y_valid=%0b y=%0d, want 8 0 0 0",
               count, level, y_valid, y);
    end
  endtask

  task automatic test_full();
    logic [1:0] exp_y;
    for (int i = 0; i < 8; i++) push(2'(i));
    in_valid = 1'b1;
    in_sym   = 2'd3;
    adv      = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got in_ready=%0b, want 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    adv      = 1'b0;
    n_tests++;
    if (level !== 4'd7 || count !== 8'd9) begin
      n_fail++;
      $display("FAIL full_drop: got level=%0d count=%0d, want 7 9", level, count);
    end
    adv = 1'b1;
    for (int i = 1; i < 8; i++) begin
      exp_y = 2'(i);
      n_tests++;
      if (y !== exp_y || y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: got y=%0d y_valid=%0b, want %0d 1", i, y, y_valid, exp_y);
      end
      step();
    end
    adv = 1'b0;
    n_tests++;
    if (level !== 4'd0 || count !== 8'd16 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: got level=%0d count=%0d underrun=%0b, want 0 16 0",
               level, count, underrun);
    end
  endtask

  task automatic test_underrun();
    in_valid = 1'b1;
    in_sym   = 2'd2;
    adv      = 1'b1;
    step();
    in_valid = 1'b0;
    adv      = 1'b0;
    n_tests++;
    if (underrun !== 1'b1 || count !== 8'd16 || y !== 2'd2 || y_valid !== 1'b1 ||
        level !== 4'd1) begin
      n_fail++;
      $display("FAIL underrun_set: got underrun=%0b count=%0d y=%0d y_valid=%0b level=%0d, want 1 16 2 1 1",
               underrun, count, y, y_valid, level);
    end
    adv = 1'b1;
    step();
    adv = 1'b0;
    step();
    n_tests++;
    if (underrun !== 1'b1 || count !== 8'd17 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL underrun_sticky: got underrun=%0b count=%0d level=%0d, want 1 17 0",
               underrun, count, level);
    end
  endtask

  task automatic test_concurrent();
    push(2'd3);
    push(2'd0);
    push(2'd1);
    in_valid = 1'b1;
    in_sym   = 2'd1;
    adv      = 1'b1;
    step();
    in_valid = 1'b0;
    adv      = 1'b0;
    n_tests++;
    if (level !== 4'd3 || y !== 2'd0 || count !== 8'd18) begin
      n_fail++;
      $display("FAIL concurrent: got level=%0d y=%0d count=%0d, want 3 0 18", level, y, count);
    end
    adv = 1'b1;
    step();
    adv = 1'b0;
    n_tests++;
    if (level !== 4'd2 || y !== 2'd1) begin
      n_fail++;
      $display("FAIL concurrent_order: got level=%0d y=%0d, want 2 1", level, y);
    end
    async_reset("reset_midstream");
    in_valid = 1'b1;
    in_sym   = 2'd2;
    #1;
    n_tests++;
    if (y_valid !== 1'b0 || y !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_bypass: got y=%0d y_valid=%0b, want 0 0", y, y_valid);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if (y !== 2'd2 || y_valid !== 1'b1 || level !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: got y=%0d y_valid=%0b level=%0d, want 2 1 1", y, y_valid, level);
    end
  endtask

`ifdef FSM_STIM_LOOP_EN
  task automatic test_loop();
    logic [1:0] exp_seq [7] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
    async_reset("reset_loop");
    push(2'd1);
    push(2'd3);
    push(2'd2);
    loop = 1'b1;
    adv  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (y !== exp_seq[i] || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_y[%0d]: got y=%0d in_ready=%0b, want %0d 0", i, y, in_ready, exp_seq[i]);
      end
      step();
    end
    adv = 1'b0;
    n_tests++;
    if (level !== 4'd3 || count !== 8'd7 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_end: got level=%0d count=%0d in_ready=%0b, want 3 7 0",
               level, count, in_ready);
    end
    loop = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sym   = 2'd0;
    adv      = 1'b0;
    loop     = 1'b0;
    #12;
    reset = 1'b0;
    step();
    test_reset();
    test_ordered();
    test_full();
    test_underrun();
    test_concurrent();
`ifdef FSM_STIM_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
